uart_rx_module: RTL and testbench



---
 rtl/uart_rx_module_pkg.sv | 20 ++
 rtl/uart_rx_module_if.sv | 30 +++
 rtl/uart_rx_module_sync2.sv | 23 ++
 rtl/uart_rx_module.sv | 128 ++++++++++++
 tb/tb_uart_rx_module.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_module_pkg.sv
// Shared UART definitions: receiver FSM state encodings and the default baud
// divider. The transmit stage uses the same divider, so both ends stay locked
// to one bit rate.
package uart_rx_module_pkg;

  // clk cycles per UART bit (~115200 bps at the current PCLK)
  localparam int UART_CLKS_PER_BIT = 1216;

  // rx_flag high time, long enough for a 3-FF rising-edge detector downstream
  localparam int UART_FLAG_CYCLES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_module_if.sv
// Receiver-side signal bundle: serial line in, received byte and status out.
//
// Handshake: rx_flag is a valid-only strobe with no ready. It is held high for
// FLAG_CYCLES clocks per good byte, and rx_data is stable for the whole time it
// is high and afterwards, until the next good frame. The consumer is expected to
// edge-detect rx_flag. frame_err is a single-cycle strobe. state is the live
// receiver FSM state for observation.
interface uart_rx_module_if;
  import uart_rx_module_pkg::*;

  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       rx_busy;
  logic       frame_err;
  rx_state_e  state;

  // receiver side: drives the byte/status outputs
  modport master (
    input  rxd,
    output rx_data, rx_flag, rx_busy, frame_err, state
  );

  // line driver / consumer side
  modport slave (
    output rxd,
    input  rx_data, rx_flag, rx_busy, frame_err, state
  );

endinterface

// File: rtl/uart_rx_module_sync2.sv
// Two-flop synchronizer for the asynchronous serial input. Both flops reset
// to 1 so the line reads as idle during and right after reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the async input through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver, LSB first. The start bit is validated at its middle,
// then each data bit and the stop bit are sampled one full bit period later.
// A good byte updates rx_data and raises a stretched rx_flag; a low stop bit
// produces one frame_err pulse and the receiver waits for the line to go idle.
module uart_rx_module
  import uart_rx_module_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FLAG_CYCLES  = UART_FLAG_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_module_if.master rx
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int FLAG_W = $clog2(FLAG_CYCLES + 1);
  localparam int HALF   = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [FLAG_W-1:0] FLAG_LOAD = FLAG_W'(FLAG_CYCLES);

  rx_state_e         state;
  logic              rxd_s;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic [7:0]        rx_data_q;
  logic [FLAG_W-1:0] flag_cnt;
  logic              frame_err_q;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx.rxd),
    .q   (rxd_s)
  );

  // receive FSM with bit timing, data capture and flag stretcher
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data_q   <= '0;
      flag_cnt    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (flag_cnt != '0) begin
        flag_cnt <= flag_cnt - 1'b1;
      end

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxd_s) begin
            state <= ST_START;
          end
        end

        // confirm the start bit at its middle; a high line here is a glitch
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // one full bit period after mid-start lands in the middle of each data bit
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxd_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // leave at mid-stop so a back-to-back start edge is not missed
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              rx_data_q <= shreg;
              flag_cnt  <= FLAG_LOAD;
              state     <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // a line held low counts as one error, not a stream of frames
        ST_BREAK: begin
          cnt <= '0;
          if (rxd_s) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_flag   = (flag_cnt != '0);
  assign rx.rx_busy   = (state != ST_IDLE);
  assign rx.frame_err = frame_err_q;
  assign rx.state     = state;

endmodule

// File: tb/tb_uart_rx_module.sv
// Bench for uart_rx_module at CLKS_PER_BIT=16, FLAG_CYCLES=4: a table of single
// frames plus hand-written sequences for glitch, back-to-back, reset mid-frame
// and a loopback through a small model of the downstream transmit stage.
module tb_uart_rx_module;
  import uart_rx_module_pkg::*;

  localparam int CPB   = 16;
  localparam int FLAGC = 4;
  localparam int LAT   = 2 + CPB / 2 + 9 * CPB + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_module_if rx_if ();

  uart_rx_module #(
    .CLKS_PER_BIT (CPB),
    .FLAG_CYCLES  (FLAGC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx_if.master)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  logic       prev_flag   = 1'b0;
  logic       prev_err    = 1'b0;
  int         flag_len    = 0;
  int         err_len     = 0;
  int         flag_pulses = 0;
  int         err_pulses  = 0;
  int         rise_cyc    = 0;
  int         fall_cyc    = 0;
  int         unstable    = 0;
  logic [7:0] held        = '0;

  always begin
    @(posedge clk);
    #1;
    if (rx_if.rx_flag) begin
      if (!prev_flag) begin
        flag_pulses++;
        rise_cyc = cyc;
        held     = rx_if.rx_data;
        flag_len = 0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_flag: rx_flag rose with rx_data 0x%0h, no byte expected", rx_if.rx_data);
        end else begin
          check("sb_rx_data", rx_if.rx_data, exp_q.pop_front());
        end
      end else if (rx_if.rx_data !== held) begin
        unstable++;
      end
      flag_len++;
    end else if (prev_flag) begin
      check("flag_len", flag_len, FLAGC);
    end

    if (rx_if.frame_err) begin
      if (!prev_err) begin
        err_pulses++;
        err_len = 0;
      end
      err_len++;
    end else if (prev_err) begin
      check("err_len", err_len, 1);
    end

    prev_flag = rx_if.rx_flag;
    prev_err  = rx_if.frame_err;
  end

  // ---------------- downstream transmit stage model ----------------
  logic [2:0] flag_sync = 3'b000;
  logic [9:0] tx_sh     = '1;
  int         tx_bits   = 0;
  int         tx_cnt    = 0;
  logic       tx_line;
  assign tx_line = tx_sh[0];

  always @(posedge clk) begin
    flag_sync <= {flag_sync[1:0], rx_if.rx_flag};
    if (tx_bits == 0) begin
      if (flag_sync[1] && !flag_sync[2]) begin
        tx_sh   <= {1'b1, rx_if.rx_data, 1'b0};
        tx_bits <= 10;
        tx_cnt  <= 0;
      end
    end else if (tx_cnt == CPB - 1) begin
      tx_cnt  <= 0;
      tx_sh   <= {1'b1, tx_sh[9:1]};
      tx_bits <= tx_bits - 1;
    end else begin
      tx_cnt <= tx_cnt + 1;
    end
  end

  // ---------------- driver ----------------
  // Call at a negedge; returns at a negedge, so gap=0 gives back-to-back frames.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int gap);
    rx_if.rxd = 1'b0;
    fall_cyc  = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.rxd = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx_if.rxd = stop_bit;
    if (stop_bit) repeat (CPB) @(negedge clk);
    else          repeat (40) @(negedge clk);
    rx_if.rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_flags;
    int         exp_errs;
  } vec_t;

  vec_t vecs[5];

  int         f0;
  int         e0;
  int         w;
  logic [7:0] got_byte;
  logic       got_stop;
  logic [7:0] part;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1, 0};
    vecs[2] = '{8'h5A, 1'b0, 8'h3C, 0, 1};  // bad stop: previous byte kept
    vecs[3] = '{8'hE7, 1'b1, 8'hE7, 1, 0};
    vecs[4] = '{8'h12, 1'b1, 8'h12, 1, 0};

    rx_if.rxd = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_rx_data",   rx_if.rx_data,   8'h00);
    check("rst_rx_flag",   rx_if.rx_flag,   1'b0);
    check("rst_rx_busy",   rx_if.rx_busy,   1'b0);
    check("rst_frame_err", rx_if.frame_err, 1'b0);
    check("rst_state",     rx_if.state,     ST_IDLE);
    repeat (4) @(negedge clk);

    // single frames from the table
    for (int i = 0; i < 5; i++) begin
      f0 = flag_pulses;
      e0 = err_pulses;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, 60);
      check($sformatf("vec%0d_rx_data", i), rx_if.rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_flags", i), flag_pulses - f0, vecs[i].exp_flags);
      check($sformatf("vec%0d_errs", i), err_pulses - e0, vecs[i].exp_errs);
      check($sformatf("vec%0d_busy", i), rx_if.rx_busy, 1'b0);
      check($sformatf("vec%0d_state", i), rx_if.state, ST_IDLE);
      if (vecs[i].exp_flags == 1) begin
        check($sformatf("vec%0d_latency", i), rise_cyc - fall_cyc, LAT);
      end
    end

    // back-to-back 0x00 then 0xFF with no idle gap
    f0 = flag_pulses;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 60);
    check("b2b_flags",   flag_pulses - f0, 2);
    check("b2b_rx_data", rx_if.rx_data, 8'hFF);

    // start glitch: 5 low cycles is rejected at mid-start
    f0 = flag_pulses;
    e0 = err_pulses;
    rx_if.rxd = 1'b0;
    repeat (5) @(negedge clk);
    rx_if.rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_in_start", rx_if.state, ST_START);
    repeat (20) @(negedge clk);
    check("glitch_state", rx_if.state, ST_IDLE);
    check("glitch_flags", flag_pulses - f0, 0);
    check("glitch_errs",  err_pulses - e0, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 60);
    check("glitch_next_rx_data", rx_if.rx_data, 8'h3C);
    check("glitch_next_flags",   flag_pulses - f0, 1);

    // reset in the middle of DATA, after bit 3 has been sampled
    f0   = flag_pulses;
    e0   = err_pulses;
    part = 8'h55;
    rx_if.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_if.rxd = part[i];
      repeat (CPB) @(negedge clk);
    end
    check("mid_busy_before_rst", rx_if.state, ST_DATA);
    rx_if.rxd = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    check("midrst_rx_data",   rx_if.rx_data,   8'h00);
    check("midrst_rx_flag",   rx_if.rx_flag,   1'b0);
    check("midrst_rx_busy",   rx_if.rx_busy,   1'b0);
    check("midrst_frame_err", rx_if.frame_err, 1'b0);
    check("midrst_state",     rx_if.state,     ST_IDLE);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst_flags", flag_pulses - f0, 0);
    check("midrst_errs",  err_pulses - e0, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 60);
    check("midrst_next_rx_data", rx_if.rx_data, 8'h81);

    // loopback through the transmit stage model
    repeat (300) @(negedge clk);
    exp_q.push_back(8'hC3);
    fork
      send_frame(8'hC3, 1'b1, 0);
    join_none
    w = 0;
    while (tx_line !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("loop_tx_start_seen", tx_line, 1'b0);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      got_byte[i] = tx_line;
    end
    repeat (CPB) @(negedge clk);
    got_stop = tx_line;
    check("loop_tx_byte", got_byte, 8'hC3);
    check("loop_tx_stop", got_stop, 1'b1);
    repeat (60) @(negedge clk);

    // end-of-run scoreboard state
    check("sb_queue_empty",   exp_q.size(), 0);
    check("rx_data_stable",   unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
